// File: rtl/fifo_reader_pkg.sv
// Shared types and constants for the FIFO stream reader: buffer state encoding
// and output buffer depth.
package fifo_reader_pkg;

    localparam int BUF_DEPTH = 2;

    // Encoded so the state value equals the number of buffered words
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_t;

    function automatic logic [1:0] buf_occ(input buf_state_t s);
        return logic'(s == ONE) ? 2'd1 : (s == TWO) ? 2'd2 : 2'd0;
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read-side and valid/ready stream signals of the FIFO stream reader.
// master: the reader (pops the FIFO, drives the stream); slave: FIFO + sink.
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic                  fifo_rd_en;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;

    modport master (
        input  fifo_empty,
        input  fifo_rdata,
        input  m_ready,
        output fifo_rd_en,
        output m_valid,
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_rdata,
        output m_ready,
        input  fifo_rd_en,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/fifo_reader_buf.sv
// Two-entry output buffer of the FIFO stream reader; head word and valid are
// registered so the stream outputs come straight from flops.
//
// state | meaning
// EMPTY | no word buffered, rd_valid=0
// ONE   | head word in rd_data
// TWO   | head word in rd_data, next word in slot1
module fifo_reader_buf
    import fifo_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  rd_clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [1:0]            occupancy
);

    buf_state_t            state;
    logic [DATA_WIDTH-1:0] slot1;

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            state    <= EMPTY;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            slot1    <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (wr_en) begin
                        rd_data  <= wr_data;
                        rd_valid <= 1'b1;
                        state    <= ONE;
                    end
                end
                ONE: begin
                    case ({wr_en, pop})
                        2'b11: rd_data <= wr_data;
                        2'b10: begin
                            slot1 <= wr_data;
                            state <= TWO;
                        end
                        2'b01: begin
                            rd_valid <= 1'b0;
                            state    <= EMPTY;
                        end
                        default: ;
                    endcase
                end
                TWO: begin
                    // A write without a pop cannot occur here: the read request
                    // logic never lets a third word into flight.
                    if (pop) begin
                        rd_data <= slot1;
                        if (wr_en) slot1 <= wr_data;
                        else       state <= ONE;
                    end
                end
                default: begin
                    rd_valid <= 1'b0;
                    state    <= EMPTY;
                end
            endcase
        end
    end

    assign occupancy = buf_occ(state);

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains an async FIFO read port into a 2-entry buffer presented as a
// valid/ready stream. Define FIFO_READER_CNT_EN to add the rd_count port.
module fifo_stream_reader
    import fifo_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 rd_clk,
    input  logic                 rst,
    fifo_stream_reader_if.master bus
`ifdef FIFO_READER_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] rd_count
`endif
);

    logic                  pending;
    logic                  pop;
    logic                  rd_en;
    logic [1:0]            occ;
    logic                  buf_valid;
    logic [DATA_WIDTH-1:0] buf_data;

    assign pop = buf_valid & bus.m_ready;

    // Words buffered plus in flight after this edge must leave room for one more
    assign rd_en = ~rst & ~bus.fifo_empty &
                   (({1'b0, occ} + {2'b00, pending}) < (3'(BUF_DEPTH) + {2'b00, pop}));

    always_ff @(posedge rd_clk) begin
        if (rst) pending <= 1'b0;
        else     pending <= rd_en & ~bus.fifo_empty;
    end

    fifo_reader_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .rd_clk   (rd_clk),
        .rst      (rst),
        .wr_en    (pending),
        .wr_data  (bus.fifo_rdata),
        .pop      (pop),
        .rd_valid (buf_valid),
        .rd_data  (buf_data),
        .occupancy(occ)
    );

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = buf_valid;
    assign bus.m_data     = buf_data;

`ifdef FIFO_READER_CNT_EN
    always_ff @(posedge rd_clk) begin
        if (rst)      rd_count <= '0;
        else if (pop) rd_count <= rd_count + 1'b1;
    end
`endif

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of FIFO read data and stream data.
REQ-002 Parameter CNT_WIDTH, default 32: width of the delivered-word counter.
REQ-003 rd_clk  input  1  sole clock; all state updates on posedge rd_clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 fifo_empty  input  1  read-side empty flag of the upstream async FIFO.
REQ-006 fifo_rdata  input  DATA_WIDTH  FIFO read data, valid in the cycle after a cycle with fifo_rd_en=1 and fifo_empty=0.
REQ-007 fifo_rd_en  output  1  pop request to the FIFO.
REQ-008 m_valid  output  1  stream data valid.
REQ-009 m_data  output  DATA_WIDTH  stream data.
REQ-010 m_ready  input  1  downstream accept.
REQ-011 rd_count  output  CNT_WIDTH  count of delivered words (only with FIFO_READER_CNT_EN).

Function
REQ-012 The block shall drain the FIFO into a 2-entry output buffer and present it as a valid/ready stream; transfer occurs when m_valid=1 and m_ready=1 at a rising edge.
REQ-013 An internal 1-bit pending flag shall register (fifo_rd_en & ~fifo_empty), marking a read in flight.
REQ-014 fifo_rd_en shall be combinational: 1 iff fifo_empty=0 and (buffer occupancy + pending - pop_this_cycle) < 2, where pop_this_cycle = m_valid & m_ready.
REQ-015 When pending=1, fifo_rdata shall be written into the buffer at that edge, with no loss and no duplication.
REQ-016 Buffer states: EMPTY (0 words), ONE (1), TWO (2). Transitions: write only -> +1; pop only -> -1; write and pop together -> no change, with the head advancing correctly.
REQ-017 m_valid shall be 1 iff the state is not EMPTY, and m_data shall be the oldest buffered word; both shall be driven from registers.
REQ-018 m_data shall hold stable while m_valid=1 and m_ready=0.
REQ-019 Latency: fifo_empty falls in cycle N with the buffer EMPTY -> fifo_rd_en=1 in cycle N -> m_valid=1 in cycle N+2.
REQ-020 Throughput: with the FIFO non-empty and m_ready held at 1, the block shall deliver one word per cycle, and fifo_rd_en shall stay at 1.
REQ-021 Backpressure: with m_ready=0, at most 2 words shall be buffered or in flight, after which fifo_rd_en shall go to 0.
REQ-022 The buffer shall never overflow, including when pending=1 and the state is TWO with a pop in the same cycle.
REQ-023 fifo_empty=1 shall suppress fifo_rd_en regardless of buffer space.

Reset
REQ-024 While rst=1 at an edge: state=EMPTY, pending=0, buffer data=0, rd_count=0.
REQ-025 During and after reset: m_valid=0, m_data=0, and fifo_rd_en=0 while rst=1.
REQ-026 Reset asserted mid-transfer shall discard buffered and in-flight words, and the fifo_rdata arriving in the following cycle shall be ignored.

Configuration
REQ-027 Macro FIFO_READER_CNT_EN defined: port rd_count exists and increments by 1 on each stream transfer, wrapping from 2**CNT_WIDTH-1 to 0.
REQ-028 Macro FIFO_READER_CNT_EN undefined: the rd_count port and its counter logic are absent, and all other behaviour is identical.

Structure
REQ-029 Shared package fifo_reader_pkg shall hold the buffer state enum typedef (EMPTY/ONE/TWO) and the constant BUF_DEPTH=2.
REQ-030 The 2-entry buffer shall be a sub-module, fifo_reader_buf (write port, pop port, occupancy output).
REQ-031 Top-level fifo_stream_reader shall contain the pending flag, fifo_rd_en logic, the counter, and one fifo_reader_buf instance.

Verification
REQ-032 Single word: FIFO model holds 0xA5A5A5A5, m_ready=1 -> one fifo_rd_en pulse, m_valid=1 exactly 2 cycles later with m_data=0xA5A5A5A5, then m_valid=0.
REQ-033 Streaming: 16 words 0..15 preloaded, m_ready=1 -> 16 consecutive cycles of m_valid=1 with data 0..15 in order, and rd_count=16.
REQ-034 Backpressure: 8 words preloaded, m_ready=0 for 10 cycles -> exactly 2 pops issued, m_data=0 held stable; release m_ready -> words 0..7 delivered in order, none lost.
REQ-035 Random m_ready (50%) with a FIFO model toggling fifo_empty -> output sequence equals input sequence, and occupancy+pending never exceeds 2.
REQ-036 rst asserted for 1 cycle with TWO buffered and pending=1 -> m_valid=0 next cycle, stale fifo_rdata dropped, rd_count=0; the next preloaded word 0x1 is delivered first.
REQ-037 With FIFO_READER_CNT_EN and CNT_WIDTH=4, 17 transfers -> rd_count=1 after wrap; rebuild without the macro -> identical stream output.
